// File: rtl/nb_ctrl_pkg.sv
// Shared types and constants for the noise-blanker threshold controller.
// Accumulator is unsigned fixed point: DAT_W integer bits over FRAC fraction bits.
package nb_ctrl_pkg;

  localparam int DAT_W = 12;
  localparam int FRAC  = 4;
  localparam int ACC_W = 16;

  localparam logic [DAT_W-1:0] LIM_MAX = 12'hFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_DRAIN = 3'd2,
    S_CAPT  = 3'd3,
    S_AVG   = 3'd4,
    S_SCALE = 3'd5
  } nb_state_t;

endpackage

// File: rtl/nb_thresh_ctrl_if.sv
// Blanker-side bundle: sample strobe and peak in, peak reset and limit out.
// master = threshold controller, slave = blanker (or its stand-in).
interface nb_thresh_ctrl_if;
  import nb_ctrl_pkg::*;

  logic             iv;
  logic [DAT_W-1:0] peak;
  logic             pkrst;
  logic [DAT_W-1:0] limit;

  modport master (input iv, input peak, output pkrst, output limit);
  modport slave  (output iv, output peak, input pkrst, input limit);
endinterface

// File: rtl/nb_ctrl_scale.sv
// Combinational gain stage: limit = min(avg * mult / 8, 4095).
// Registered by the parent; mult is in eighths.
module nb_ctrl_scale
  import nb_ctrl_pkg::*;
(
  input  logic [DAT_W-1:0] avg,
  input  logic [5:0]       mult,
  output logic [DAT_W-1:0] lim
);

  logic [17:0] p;
  logic [14:0] q;

  assign p   = {6'd0, avg} * {12'd0, mult};
  assign q   = 15'(p >> 3);
  assign lim = (q > 15'd4095) ? LIM_MAX : q[DAT_W-1:0];

endmodule

// File: rtl/nb_thresh_ctrl.sv
// Adaptive noise-blanker threshold: windowed peak capture, leaky average, scaled limit.
// Window-closing iv at edge n -> new limit/upd after edge n+PKLAT+3; manual limit when en=0.
module nb_thresh_ctrl
  import nb_ctrl_pkg::*;
#(
  parameter int PKLAT = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                en,
  input  logic [15:0]         win,
  input  logic [2:0]          k,
  input  logic [5:0]          mult,
  input  logic [DAT_W-1:0]    mlimit,
  output logic [DAT_W-1:0]    avg,
  output logic                upd,
  nb_thresh_ctrl_if.master    bus
);

  localparam logic [15:0] WIN_MIN   = 16'(PKLAT + 4);
  localparam logic [7:0]  DRAIN_END = 8'(PKLAT - 1);

  nb_state_t          state;
  logic [15:0]        cnt;
  logic [7:0]         dcnt;
  logic               first;
  logic [DAT_W-1:0]   pk_q;
  logic [ACC_W-1:0]   acc;
  logic [DAT_W-1:0]   limit_q;
  logic               pkrst_q;
  logic               upd_q;

  logic [15:0]        win_eff;
  logic               wrap;
  logic signed [16:0] diff;
  logic [ACC_W-1:0]   acc_nxt;
  logic [DAT_W-1:0]   lim_scaled;

  // Short windows would let a new wrap arrive before the capture pipeline returns to COUNT.
  assign win_eff = (win < WIN_MIN) ? WIN_MIN : win;
  assign wrap    = (cnt == win_eff - 16'd1);

  assign diff    = $signed({1'b0, pk_q, {FRAC{1'b0}}}) - $signed({1'b0, acc});
  assign acc_nxt = ACC_W'($signed({1'b0, acc}) + (diff >>> k));

  assign avg       = acc[ACC_W-1:FRAC];
  assign bus.limit = limit_q;
  assign bus.pkrst = pkrst_q;
  assign upd       = upd_q;

  nb_ctrl_scale u_scale (
    .avg  (avg),
    .mult (mult),
    .lim  (lim_scaled)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= 16'd0;
      dcnt    <= 8'd0;
      first   <= 1'b1;
      pk_q    <= '0;
      acc     <= '0;
      limit_q <= LIM_MAX;
      pkrst_q <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      pkrst_q <= 1'b0;
      upd_q   <= 1'b0;

      if (state != S_IDLE && bus.iv) begin
        cnt <= wrap ? 16'd0 : cnt + 16'd1;
      end

      if (state == S_IDLE) begin
        limit_q <= mlimit;
        if (en) begin
          state   <= S_COUNT;
          pkrst_q <= 1'b1;
          cnt     <= 16'd0;
          first   <= 1'b1;
        end
      end else if (!en) begin
        // Dropping auto mode abandons the window; acc keeps its value.
        state <= S_IDLE;
      end else begin
        case (state)
          S_COUNT: begin
            if (bus.iv && wrap) begin
              state <= S_DRAIN;
              dcnt  <= 8'd0;
            end
          end
          S_DRAIN: begin
            if (dcnt == DRAIN_END) begin
              state   <= S_CAPT;
              pkrst_q <= 1'b1;
            end else begin
              dcnt <= dcnt + 8'd1;
            end
          end
          S_CAPT: begin
            pk_q  <= bus.peak;
            state <= S_AVG;
          end
          S_AVG: begin
            acc   <= first ? {pk_q, {FRAC{1'b0}}} : acc_nxt;
            first <= 1'b0;
            state <= S_SCALE;
          end
          S_SCALE: begin
            limit_q <= lim_scaled;
            upd_q   <= 1'b1;
            state   <= S_COUNT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
